// File: rtl/gemm_issue_ctrl.sv
// gemm_issue_ctrl
//
// Issue controller between the core's execute stage and a GEMM accelerator.
// It queues ISSUE commands ({rs1, rs2}) in a small FIFO and launches them one at
// a time through a start/done handshake. It stalls the core on a full queue or on
// a WAIT while work is outstanding. Each running job is supervised by a timeout,
// and non-idle cycles are counted.
//
// Ports:
//   clk          core clock, rising edge
//   rst          asynchronous reset, active low
//   gemm_valid   execute-stage instruction is a GEMM instruction
//   gemm_func3   3'b000 ISSUE, 3'b001 WAIT, others no-op
//   flush        kill the execute-stage instruction this cycle
//   rs1_data     operand A (config word A)
//   rs2_data     operand B (config word B)
//   gemm_done    one-cycle completion pulse from the accelerator
//   err_clr      clears err_timeout
//   acc_start    one-cycle start pulse to the accelerator
//   acc_cfg_a/b  operands of the launched job; hold their value between launches
//   gemm_stall   hold the core pipeline this cycle
//   busy         queue non-empty or a job is starting or running
//   err_timeout  sticky hung-job flag
//   perf_cycles  saturating count of non-idle cycles
module gemm_issue_ctrl #(
    parameter int DEPTH       = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gemm_valid,
    input  logic [2:0]  gemm_func3,
    input  logic        flush,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        gemm_done,
    input  logic        err_clr,
    output logic        acc_start,
    output logic [31:0] acc_cfg_a,
    output logic [31:0] acc_cfg_b,
    output logic        gemm_stall,
    output logic        busy,
    output logic        err_timeout,
    output logic [31:0] perf_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [31:0]   TMO_LAST   = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } state_t;

    state_t state, next_state;

    logic [63:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [31:0]    tmo_cnt;

    logic fifo_empty, fifo_full;
    logic is_issue, is_wait;
    logic push, pop, timeout;
    logic [63:0] head;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign is_issue   = (gemm_func3 == 3'b000);
    assign is_wait    = (gemm_func3 == 3'b001);
    assign head       = mem[rd_ptr];

    assign busy       = !fifo_empty || (state != IDLE);
    // Stall depends only on the instruction and registered state, never on flush.
    // The full check ignores a same-cycle pop on purpose (no bypass path).
    assign gemm_stall = gemm_valid && ((is_issue && fifo_full) || (is_wait && busy));
    assign push       = gemm_valid && !flush && !gemm_stall && is_issue;
    assign pop        = (state == START);
    // gemm_done in the final cycle wins over the timeout.
    assign timeout    = (state == RUN) && !gemm_done && (tmo_cnt == TMO_LAST);
    assign acc_start  = (state == START);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; gemm_done only matters while RUN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty) next_state = START;
            START:   next_state = RUN;
            RUN: begin
                if (gemm_done) begin
                    next_state = fifo_empty ? IDLE : START;
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {rs1_data, rs2_data};
        end
    end

    // FIFO pointers and occupancy. A timeout drops every queued entry, but an
    // ISSUE accepted in that same cycle is still kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (timeout) begin
                rd_ptr <= wr_ptr;
                count  <= push ? CW'(1) : '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (!push && pop) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // The head is latched on entry to START, so the config is valid during the
    // start pulse and then holds until the next launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cfg_a <= '0;
            acc_cfg_b <= '0;
        end else if (next_state == START && state != START) begin
            acc_cfg_a <= head[63:32];
            acc_cfg_b <= head[31:0];
        end
    end

    // Timeout counter, cleared in START so it starts at zero on entry to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == START) begin
            tmo_cnt <= '0;
        end else if (state == RUN) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    // Sticky error flag; setting wins over clearing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_timeout <= 1'b0;
        end else if (timeout) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

    // Saturating non-idle cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
        end else if (state != IDLE && perf_cycles != 32'hFFFF_FFFF) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_gemm_issue_ctrl.sv
// tb_gemm_issue_ctrl
//
// Self-checking bench for gemm_issue_ctrl. A transaction-level reference model
// (a queue of pending configs plus launch/run flags) advances once per clock.
// Each scenario task compares DUT outputs inline against that model or against
// fixed expectations.
module tb_gemm_issue_ctrl;

    localparam int DEPTH = 2;
    localparam int TMO   = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gemm_valid = 1'b0;
    logic [2:0]  gemm_func3 = 3'b000;
    logic        flush = 1'b0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        gemm_done = 1'b0;
    logic        err_clr = 1'b0;
    logic        acc_start;
    logic [31:0] acc_cfg_a, acc_cfg_b;
    logic        gemm_stall, busy, err_timeout;
    logic [31:0] perf_cycles;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    logic [63:0] mq[$];
    bit          m_launch, m_run, m_err;
    int          m_rc;
    logic [31:0] m_perf;
    logic [63:0] m_last;

    gemm_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .gemm_valid(gemm_valid), .gemm_func3(gemm_func3),
        .flush(flush), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .gemm_done(gemm_done), .err_clr(err_clr), .acc_start(acc_start),
        .acc_cfg_a(acc_cfg_a), .acc_cfg_b(acc_cfg_b), .gemm_stall(gemm_stall),
        .busy(busy), .err_timeout(err_timeout), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit exp_busy();
        return (mq.size() != 0) || m_launch || m_run;
    endfunction

    function automatic bit exp_stall();
        return gemm_valid && ((gemm_func3 == 3'b000 && mq.size() == DEPTH) ||
                              (gemm_func3 == 3'b001 && exp_busy()));
    endfunction

    function automatic logic [63:0] exp_cfg();
        return m_launch ? mq[0] : m_last;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_launch = 0; m_run = 0; m_err = 0; m_rc = 0;
        m_perf = '0; m_last = '0;
    endtask

    // One clock of the reference model, using the inputs present at the edge.
    task automatic model_step();
        bit acc = gemm_valid && !flush && !exp_stall() && gemm_func3 == 3'b000;
        int pre = mq.size();
        bit to  = 0;
        if ((m_launch || m_run) && m_perf != 32'hFFFF_FFFF) m_perf++;
        if (m_launch) begin
            m_last = mq.pop_front();
            m_launch = 0; m_run = 1; m_rc = 0;
        end else if (m_run) begin
            if (gemm_done) begin
                m_run = 0;
                m_launch = (pre != 0);
            end else if (m_rc == TMO - 1) begin
                to = 1; m_run = 0; mq.delete();
            end else begin
                m_rc++;
            end
        end else if (pre != 0) begin
            m_launch = 1;
        end
        if (to) m_err = 1;
        else if (err_clr) m_err = 0;
        if (acc) mq.push_back({rs1_data, rs2_data});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        gemm_valid = 0; gemm_func3 = 3'b000; flush = 0;
        rs1_data = '0; rs2_data = '0; gemm_done = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (acc_start !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_start: got %b exp 0", acc_start); end
        n_total++; if (acc_cfg_a !== 32'd0 || acc_cfg_b !== 32'd0) begin n_bad++; $display("[TB] FAIL rst_cfg: got %h/%h exp 0", acc_cfg_a, acc_cfg_b); end
        n_total++; if (busy !== 1'b0 || gemm_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_busy_stall: got %b/%b exp 0/0", busy, gemm_stall); end
        n_total++; if (err_timeout !== 1'b0 || perf_cycles !== 32'd0) begin n_bad++; $display("[TB] FAIL rst_err_perf: got %b/%0d exp 0/0", err_timeout, perf_cycles); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_single_job();
        gemm_valid = 1; gemm_func3 = 3'b000; rs1_data = 32'h1000; rs2_data = 32'h0004_0004;
        #1;
        n_total++; if (gemm_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL single_stall: got %b exp 0", gemm_stall); end
        tick(); idle_in(); #1;
        n_total++; if (acc_start !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("[TB] FAIL single_t1: got start=%b busy=%b exp 0/1", acc_start, busy); end
        tick(); #1;
        n_total++; if (acc_start !== 1'b1) begin n_bad++; $display("[TB] FAIL single_latency: got %b exp 1", acc_start); end
        n_total++; if (acc_cfg_a !== 32'h1000 || acc_cfg_b !== 32'h0004_0004) begin n_bad++; $display("[TB] FAIL single_cfg: got %h/%h exp 00001000/00040004", acc_cfg_a, acc_cfg_b); end
        tick();
        for (int i = 1; i <= 10; i++) begin
            gemm_done = (i == 10);
            #1;
            n_total++; if (busy !== 1'b1 || acc_start !== 1'b0) begin n_bad++; $display("[TB] FAIL single_run%0d: got busy=%b start=%b exp 1/0", i, busy, acc_start); end
            tick();
        end
        gemm_done = 0; #1;
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL single_busy_fall: got %b exp 0", busy); end
        n_total++; if (perf_cycles !== m_perf) begin n_bad++; $display("[TB] FAIL single_perf: got %0d exp %0d", perf_cycles, m_perf); end
        n_total++; if (acc_cfg_a !== 32'h1000) begin n_bad++; $display("[TB] FAIL single_cfg_hold: got %h exp 00001000", acc_cfg_a); end
        tick();
    endtask

    task automatic test_queue_full();
        int k = 1, since = -1, stalls3 = 0;
        logic [31:0] got[$];
        for (int g = 0; g < 50; g++) begin
            gemm_valid = (k <= 3); gemm_func3 = 3'b000;
            rs1_data = k; rs2_data = k;
            gemm_done = (since == 3);
            #1;
            n_total++; if (gemm_stall !== exp_stall()) begin n_bad++; $display("[TB] FAIL qfull_stall: got %b exp %b", gemm_stall, exp_stall()); end
            n_total++; if (acc_start !== m_launch) begin n_bad++; $display("[TB] FAIL qfull_start: got %b exp %b", acc_start, m_launch); end
            if (acc_start) begin
                got.push_back(acc_cfg_a);
                n_total++; if (acc_cfg_b !== acc_cfg_a) begin n_bad++; $display("[TB] FAIL qfull_cfg_b: got %h exp %h", acc_cfg_b, acc_cfg_a); end
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (gemm_valid && k == 3 && gemm_stall) stalls3++;
            if (gemm_valid && !gemm_stall) k++;
            tick();
        end
        idle_in();
        n_total++; if (stalls3 !== 1) begin n_bad++; $display("[TB] FAIL qfull_third_stall: got %0d exp 1", stalls3); end
        n_total++; if (got.size() !== 3) begin n_bad++; $display("[TB] FAIL qfull_count: got %0d exp 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            n_total++; if (got[i] !== 32'(i + 1)) begin n_bad++; $display("[TB] FAIL qfull_order%0d: got %0d exp %0d", i, got[i], i + 1); end
        end
    endtask

    task automatic test_wait();
        int phase = 0, since = -1, stall_cnt = 0;
        for (int g = 0; g < 30 && phase < 2; g++) begin
            gemm_valid = 1; gemm_func3 = (phase == 0) ? 3'b000 : 3'b001;
            rs1_data = 32'h7; rs2_data = 32'h7;
            gemm_done = (since == 4);
            #1;
            n_total++; if (gemm_stall !== exp_stall()) begin n_bad++; $display("[TB] FAIL wait_stall: got %b exp %b", gemm_stall, exp_stall()); end
            if (acc_start) since = 0;
            else if (since >= 0) since++;
            if (phase == 1 && gemm_stall) stall_cnt++;
            if (!gemm_stall) phase++;
            tick();
        end
        idle_in();
        n_total++; if (phase !== 2) begin n_bad++; $display("[TB] FAIL wait_release: got phase %0d exp 2", phase); end
        n_total++; if (stall_cnt !== 7) begin n_bad++; $display("[TB] FAIL wait_len: got %0d exp 7", stall_cnt); end
    endtask

    task automatic test_flush_noop();
        gemm_valid = 1; gemm_func3 = 3'b000; flush = 1; rs1_data = 32'hDEAD; rs2_data = 32'hBEEF;
        #1;
        n_total++; if (gemm_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_stall: got %b exp 0", gemm_stall); end
        tick(); idle_in();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (busy !== 1'b0 || acc_start !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_nopush: got busy=%b start=%b exp 0/0", busy, acc_start); end
            tick();
        end
        gemm_valid = 1; gemm_func3 = 3'b010;
        #1;
        n_total++; if (gemm_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL noop_stall: got %b exp 0", gemm_stall); end
        tick(); idle_in(); #1;
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL noop_busy: got %b exp 0", busy); end
        tick();
    endtask

    task automatic test_timeout();
        int starts = 0, rise = -1;
        for (int c = 0; c < 25; c++) begin
            gemm_valid = (c < 2); gemm_func3 = 3'b000;
            rs1_data = 32'h100 + c; rs2_data = 32'h200 + c;
            #1;
            n_total++; if (err_timeout !== m_err) begin n_bad++; $display("[TB] FAIL tmo_err: got %b exp %b", err_timeout, m_err); end
            n_total++; if (busy !== exp_busy()) begin n_bad++; $display("[TB] FAIL tmo_busy: got %b exp %b", busy, exp_busy()); end
            if (acc_start) starts++;
            if (err_timeout && rise < 0) rise = c;
            tick();
        end
        idle_in();
        n_total++; if (rise !== 3 + TMO) begin n_bad++; $display("[TB] FAIL tmo_rise: got %0d exp %0d", rise, 3 + TMO); end
        n_total++; if (starts !== 1) begin n_bad++; $display("[TB] FAIL tmo_discard: got %0d starts exp 1", starts); end
        gemm_done = 1; #1;
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL tmo_late_busy: got %b exp 0", busy); end
        tick(); gemm_done = 0; #1;
        n_total++; if (acc_start !== 1'b0 || err_timeout !== 1'b1) begin n_bad++; $display("[TB] FAIL tmo_late_done: got start=%b err=%b exp 0/1", acc_start, err_timeout); end
        err_clr = 1; tick(); err_clr = 0; #1;
        n_total++; if (err_timeout !== 1'b0) begin n_bad++; $display("[TB] FAIL tmo_clr: got %b exp 0", err_timeout); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        for (int c = 0; c < 5; c++) begin
            gemm_valid = (c < 2); gemm_func3 = 3'b000; rs1_data = 32'h55 + c; rs2_data = 32'h66;
            tick();
        end
        idle_in();
        #1;
        n_total++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_pre_busy: got %b exp 1", busy); end
        rst = 1'b0; #1;
        n_total++; if (busy !== 1'b0 || acc_start !== 1'b0 || err_timeout !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_flags: got busy=%b start=%b err=%b exp 0", busy, acc_start, err_timeout); end
        n_total++; if (acc_cfg_a !== 32'd0 || acc_cfg_b !== 32'd0 || perf_cycles !== 32'd0) begin n_bad++; $display("[TB] FAIL rmid_regs: got %h/%h/%0d exp 0", acc_cfg_a, acc_cfg_b, perf_cycles); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_total++; if (acc_start !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_after: got start=%b busy=%b exp 0/0", acc_start, busy); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [63:0] ec;
        for (int c = 0; c < 400; c++) begin
            gemm_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0, 1:    gemm_func3 = 3'b000;
                2:       gemm_func3 = 3'b001;
                default: gemm_func3 = 3'b010;
            endcase
            flush     = ($urandom_range(0, 7) == 0);
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            gemm_done = ($urandom_range(0, 4) == 0);
            err_clr   = ($urandom_range(0, 9) == 0);
            #1;
            ec = exp_cfg();
            n_total++; if (gemm_stall !== exp_stall()) begin n_bad++; $display("[TB] FAIL rnd_stall c%0d: got %b exp %b", c, gemm_stall, exp_stall()); end
            n_total++; if (busy !== exp_busy()) begin n_bad++; $display("[TB] FAIL rnd_busy c%0d: got %b exp %b", c, busy, exp_busy()); end
            n_total++; if (acc_start !== m_launch) begin n_bad++; $display("[TB] FAIL rnd_start c%0d: got %b exp %b", c, acc_start, m_launch); end
            n_total++; if ({acc_cfg_a, acc_cfg_b} !== ec) begin n_bad++; $display("[TB] FAIL rnd_cfg c%0d: got %h%h exp %h", c, acc_cfg_a, acc_cfg_b, ec); end
            n_total++; if (err_timeout !== m_err) begin n_bad++; $display("[TB] FAIL rnd_err c%0d: got %b exp %b", c, err_timeout, m_err); end
            n_total++; if (perf_cycles !== m_perf) begin n_bad++; $display("[TB] FAIL rnd_perf c%0d: got %0d exp %0d", c, perf_cycles, m_perf); end
            tick();
        end
        idle_in();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_job();
        test_queue_full();
        test_wait();
        test_flush_noop();
        test_timeout();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
